// File: rtl/pq_client.sv
// ---------------------------------------------------------------------------
// pq_client
// Streaming best-K selector that drives an external priority queue of depth K.
// Candidates arrive on a valid/ready stream; the client keeps the K smallest
// tags in the queue (evicting the current largest when a smaller tag arrives).
// After the candidate flagged last, it drains the queue smallest-first onto
// the result stream.
//
// Handshake: a candidate transfers on a rising clk_in edge where
// cand_valid_in && cand_ready_out. cand_ready_out is high only in IDLE.
// The result stream has no backpressure: res_valid_out is a one-cycle pulse.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   cand_*                  candidate stream (data, tag, last)
//   q_enq/deq_*_out         one-cycle requests to the queue, enq payload
//   q_valid/data/tag_in     queue dequeue response (one cycle after request)
//   q_max_tag_in            queue's scanned maximum tag
//   res_*                   ascending result stream, res_last_out on final
//   busy_out, err_out       not-IDLE, sticky response timeout
//   stat_*_out              insert / drop / eviction counters (saturating)
//   state_dbg_out           current FSM state encoding
//
// Build option: define PQ_CLIENT_STATS_EN to enable the statistics counters;
// otherwise stat_*_out are tied to zero.
// ---------------------------------------------------------------------------
module pq_client #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32,
  parameter int K          = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cand_valid_in,
  output logic                  cand_ready_out,
  input  logic [DATA_WIDTH-1:0] cand_data_in,
  input  logic [TAG_WIDTH-1:0]  cand_tag_in,
  input  logic                  cand_last_in,
  output logic                  q_enq_out,
  output logic                  q_deq_smallest_out,
  output logic                  q_deq_largest_out,
  output logic [DATA_WIDTH-1:0] q_enq_data_out,
  output logic [TAG_WIDTH-1:0]  q_enq_tag_out,
  input  logic                  q_valid_in,
  input  logic [DATA_WIDTH-1:0] q_data_in,
  input  logic [TAG_WIDTH-1:0]  q_tag_in,
  input  logic [TAG_WIDTH-1:0]  q_max_tag_in,
  output logic                  res_valid_out,
  output logic [DATA_WIDTH-1:0] res_data_out,
  output logic [TAG_WIDTH-1:0]  res_tag_out,
  output logic                  res_last_out,
  output logic                  busy_out,
  output logic                  err_out,
  output logic [15:0]           stat_acc_out,
  output logic [15:0]           stat_drop_out,
  output logic [15:0]           stat_evict_out,
  output logic [2:0]            state_dbg_out
);

  localparam int CW  = $clog2(K) + 1;
  localparam int SW  = $clog2(K + 2) + 1;
  localparam int TMO = 4 * K;
  localparam int WW  = $clog2(TMO) + 1;
  localparam logic [CW-1:0] K_C         = CW'(K);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(K + 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETTLE     = 3'd1,
    S_EVICT_WAIT = 3'd2,
    S_INSERT     = 3'd3,
    S_DRAIN_REQ  = 3'd4,
    S_DRAIN_WAIT = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  drain_q, drain_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  enq_q, enq_d;
  logic                  deqs_q, deqs_d;
  logic [DATA_WIDTH-1:0] cand_data_q, cand_data_d;
  logic [TAG_WIDTH-1:0]  cand_tag_q, cand_tag_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_last_q, res_last_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;

  logic accept_w, full_w, evict_w;

  assign accept_w = cand_valid_in && ready_q;
  assign full_w   = (cnt_q == K_C);
  // Eviction request is issued in the accept cycle itself so that it never
  // overlaps EVICT_WAIT; strict '<' makes a tie with the current max a drop.
  assign evict_w  = accept_w && full_w && (cand_tag_in < q_max_tag_in);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    wait_d      = wait_q;
    drain_d     = drain_q;
    err_d       = err_q;
    cand_data_d = cand_data_q;
    cand_tag_d  = cand_tag_q;
    res_valid_d = 1'b0;
    res_last_d  = 1'b0;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          if (cand_last_in) drain_d = 1'b1;
          if (!full_w) begin
            cand_data_d = cand_data_in;
            cand_tag_d  = cand_tag_in;
            cnt_d       = cnt_q + CNT_ONE;
            state_d     = S_INSERT;
          end else if (evict_w) begin
            cand_data_d = cand_data_in;
            cand_tag_d  = cand_tag_in;
            wait_d      = '0;
            state_d     = S_EVICT_WAIT;
          end else if (cand_last_in) begin
            // Dropped final candidate: queue is full, drain right away.
            state_d = S_DRAIN_REQ;
          end
        end
      end
      S_INSERT: begin
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // Give the queue K+2 cycles to rescan its max/min after a change.
        if (settle_q == '0) begin
          if (drain_q) state_d = (cnt_q == '0) ? S_DONE : S_DRAIN_REQ;
          else         state_d = S_IDLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_EVICT_WAIT: begin
        if (q_valid_in) begin
          state_d = S_INSERT;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DRAIN_REQ: begin
        wait_d  = '0;
        state_d = S_DRAIN_WAIT;
      end
      S_DRAIN_WAIT: begin
        if (q_valid_in) begin
          res_valid_d = 1'b1;
          res_data_d  = q_data_in;
          res_tag_d   = q_tag_in;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            res_last_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            settle_d = SETTLE_LOAD;
            state_d  = S_SETTLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DONE: begin
        drain_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered outputs follow the state being entered.
    ready_d = (state_d == S_IDLE);
    enq_d   = (state_d == S_INSERT);
    deqs_d  = (state_d == S_DRAIN_REQ);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      wait_q      <= '0;
      drain_q     <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      enq_q       <= 1'b0;
      deqs_q      <= 1'b0;
      cand_data_q <= '0;
      cand_tag_q  <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      wait_q      <= wait_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      enq_q       <= enq_d;
      deqs_q      <= deqs_d;
      cand_data_q <= cand_data_d;
      cand_tag_q  <= cand_tag_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign cand_ready_out     = ready_q;
  assign q_enq_out          = enq_q;
  assign q_deq_smallest_out = deqs_q;
  assign q_deq_largest_out  = evict_w;
  assign q_enq_data_out     = cand_data_q;
  assign q_enq_tag_out      = cand_tag_q;
  assign res_valid_out      = res_valid_q;
  assign res_data_out       = res_data_q;
  assign res_tag_out        = res_tag_q;
  assign res_last_out       = res_last_q;
  assign busy_out           = (state_q != S_IDLE);
  assign err_out            = err_q;
  assign state_dbg_out      = state_q;

`ifdef PQ_CLIENT_STATS_EN
  logic        drop_w;
  logic [15:0] acc_q, acc_d, drop_q, drop_d, evict_q, evict_d;

  assign drop_w = accept_w && full_w && !evict_w;

  always_comb begin
    acc_d   = (enq_d   && acc_q   != 16'hFFFF) ? acc_q   + 16'd1 : acc_q;
    drop_d  = (drop_w  && drop_q  != 16'hFFFF) ? drop_q  + 16'd1 : drop_q;
    evict_d = (evict_w && evict_q != 16'hFFFF) ? evict_q + 16'd1 : evict_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q   <= '0;
      drop_q  <= '0;
      evict_q <= '0;
    end else begin
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      evict_q <= evict_d;
    end
  end

  assign stat_acc_out   = acc_q;
  assign stat_drop_out  = drop_q;
  assign stat_evict_out = evict_q;
`else
  assign stat_acc_out   = 16'd0;
  assign stat_drop_out  = 16'd0;
  assign stat_evict_out = 16'd0;
`endif

endmodule
